// File: rtl/serial_adder16.sv
// Bit-serial adder: one full-adder cell and a carry flop produce {Cout, S} = A + B + Cin
// LSB first over WIDTH clocks, started by a valid/ready handshake and ending with a done pulse.
module serial_adder16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state, state_nxt;
    logic [WIDTH-1:0] opa, opb, sum;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           fa_s, fa_c;

    assign fa_s = opa[0] ^ opb[0] ^ carry;
    assign fa_c = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign start_ready = (state == IDLE) && !rst;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid && start_ready) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        opa   <= A;
                        opb   <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    // The final bit is folded in directly so S is valid in the DONE cycle.
                    if (cnt == LAST) begin
                        S    <= {fa_s, sum[WIDTH-1:1]};
                        Cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder16.sv
// Directed bench for serial_adder16: vector table plus handshake, lockout, reset-abort and
// input-stability sequences.
module tb_serial_adder16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] A, B, S;
    logic         Cin, Cout, busy, done;

    int tests  = 0;
    int failed = 0;

    serial_adder16 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        string        name;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (start_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (start_ready !== 1'b1) begin
            tests++;
            failed++;
            $display("FAIL %s: start_ready never rose, got %b, expected 1", name, start_ready);
        end
    endtask

    // Handshake on E0, then sample after E1..E(W); done must appear only after E(W).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_s, input logic exp_cout,
                         input string name, input bit scramble);
        int early = 0;
        wait_ready(name);
        A = a; B = b; Cin = cin; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (scramble) begin
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                check({name, " busy in RUN"}, busy, 1);
                check({name, " ready in RUN"}, start_ready, 0);
            end
            if (k < W && done) early++;
        end
        check({name, " early done"}, early, 0);
        check({name, " done"}, done, 1);
        check({name, " S"}, S, exp_s);
        check({name, " Cout"}, Cout, exp_cout);
        @(posedge clk);
        @(negedge clk);
        check({name, " done low"}, done, 0);
        check({name, " ready after"}, start_ready, 1);
    endtask

    initial begin
        int dones;

        vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, "basic"};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "wrap"};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "all ones"};
        vecs[3] = '{16'hFFFE, 16'h0005, 1'b0, 16'h0003, 1'b1, "sub inverse"};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, "cin only"};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "msb carry"};
        vecs[6] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, "alternating"};

        rst = 1'b1; start_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset S", S, 0);
        check("reset Cout", Cout, 0);
        check("reset done", done, 0);
        check("reset busy", busy, 0);
        check("reset ready", start_ready, 0);
        rst = 1'b0;
        #1 check("ready after reset", start_ready, 1);

        for (int i = 0; i < NV; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_s, vecs[i].exp_cout,
                  vecs[i].name, 1'b0);

        // Busy lockout: start_valid held high through the whole first operation.
        wait_ready("lockout");
        A = 16'h0001; B = 16'h0001; Cin = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = 16'hAAAA; B = 16'h5555;
        dones = 0;
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
            if (e == 16) begin
                check("lockout first S", S, 16'h0002);
                check("lockout first Cout", Cout, 0);
            end
            if (e == 17) check("lockout ready", start_ready, 1);
        end
        check("lockout first done count", dones, 1);
        dones = 0;
        for (int e = 19; e <= 34; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e < 34 && done) dones++;
        end
        start_valid = 1'b0;
        check("lockout second early done", dones, 0);
        check("lockout second done", done, 1);
        check("lockout second S", S, 16'hFFFF);
        check("lockout second Cout", Cout, 0);

        // Reset mid-operation aborts without a done pulse.
        do_op(16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, "pre-abort", 1'b0);
        A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        dones = 0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("abort S held mid-run", S, 16'h2221);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort S", S, 0);
        check("abort Cout", Cout, 0);
        check("abort busy", busy, 0);
        check("abort ready in rst", start_ready, 0);
        rst = 1'b0;
        #1 check("abort ready after rst", start_ready, 1);
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no done", dones, 0);
        check("abort S stays", S, 0);

        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "stability", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
